// File: rtl/stream_argmin_pkg.sv
// stream_argmin_pkg: shared FSM state type and index-width helper for stream_argmin.
package stream_argmin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    function automatic int idx_width(input int max_cand);
        return $clog2(max_cand + 1);
    endfunction

endpackage

// File: rtl/argmin_cell.sv
// argmin_cell: signed compare-and-select; b replaces a only when strictly smaller, so ties keep a.
module argmin_cell #(
    parameter int N     = 16,
    parameter int IDX_W = 5
) (
    input  logic signed [N-1:0]     a,
    input  logic        [IDX_W-1:0] a_idx,
    input  logic signed [N-1:0]     b,
    input  logic        [IDX_W-1:0] b_idx,
    output logic signed [N-1:0]     m,
    output logic        [IDX_W-1:0] m_idx
);

    logic take_b;

    assign take_b = b < a;
    assign m      = take_b ? b : a;
    assign m_idx  = take_b ? b_idx : a_idx;

endmodule

// File: rtl/stream_argmin.sv
// stream_argmin: streaming signed argmin over framed candidates, with truncation at MAX_CAND
// and a registered result held until downstream consumes it.
module stream_argmin
    import stream_argmin_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int Q        = 8,
    parameter  int MAX_CAND = 16,
    localparam int IDX_W    = idx_width(MAX_CAND)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     in_dist,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [N-1:0]     min_dist,
    output logic        [IDX_W-1:0] min_idx,
    output logic        [IDX_W-1:0] cand_cnt,
    output logic                    ovf
);

    if (MAX_CAND < 2 || MAX_CAND > 1024 || Q < 0 || Q >= N) begin : g_bad_param
        $error("stream_argmin: illegal parameter set");
    end

    state_t                  state, state_n;
    logic signed [N-1:0]     best, best_n, sel_dist;
    logic        [IDX_W-1:0] best_idx, idx_n, sel_idx, cnt, cnt_n;
    logic                    xfer, first, done;

    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign xfer      = in_valid && in_ready;
    assign first     = state == IDLE;

    argmin_cell #(
        .N    (N),
        .IDX_W(IDX_W)
    ) u_cell (
        .a    (best),
        .a_idx(best_idx),
        .b    (in_dist),
        .b_idx(cnt + IDX_W'(1)),
        .m    (sel_dist),
        .m_idx(sel_idx)
    );

    // The first beat of a frame seeds the running minimum instead of competing against stale state.
    always_comb begin
        state_n = state;
        best_n  = first ? in_dist : sel_dist;
        idx_n   = first ? IDX_W'(1) : sel_idx;
        cnt_n   = first ? IDX_W'(1) : cnt + IDX_W'(1);
        done    = xfer && (in_last || cnt_n == IDX_W'(MAX_CAND));
        if (state == HOLD)
            state_n = out_ready ? IDLE : HOLD;
        else if (xfer)
            state_n = done ? HOLD : ACC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            best     <= '0;
            best_idx <= '0;
            cnt      <= '0;
            min_dist <= '0;
            min_idx  <= '0;
            cand_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_n;
            if (xfer) begin
                best     <= best_n;
                best_idx <= idx_n;
                cnt      <= cnt_n;
            end
            if (done) begin
                min_dist <= best_n;
                min_idx  <= idx_n;
                cand_cnt <= cnt_n;
                ovf      <= !in_last;
            end
        end
    end

endmodule

// File: tb/tb_stream_argmin.sv
// tb_stream_argmin: directed frames plus 1000 random frames checked against a queue-based argmin model.
module tb_stream_argmin;

    localparam int N  = 16;
    localparam int MC = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_dist = '0;
    logic          in_ready, out_valid, ovf;
    logic [N-1:0]  min_dist;
    logic [IW-1:0] min_idx, cand_cnt;
    logic          done = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [N-1:0]  d;
        logic [IW-1:0] i;
        logic [IW-1:0] c;
        logic          o;
    } res_t;

    res_t         expq[$];
    logic [N-1:0] fr[$];
    logic [22:0]  prev = '0;
    logic         prev_hold = 1'b0;

    stream_argmin #(
        .N       (N),
        .Q       (8),
        .MAX_CAND(MC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dist  (in_dist),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .min_dist (min_dist),
        .min_idx  (min_idx),
        .cand_cnt (cand_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: collect accepted beats; a frame closes on last or at MC beats, first minimum wins.
    always @(negedge clk) begin
        if (rst) begin
            fr.delete();
            expq.delete();
            prev_hold = 1'b0;
        end else begin : mon
            res_t e;
            int   mi;
            if (prev_hold && out_valid)
                check("stable", {min_dist, min_idx, cand_cnt, ovf}, prev);
            if (out_valid && out_ready) begin
                check("qsize", expq.size(), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("result", {min_dist, min_idx, cand_cnt, ovf}, {e.d, e.i, e.c, e.o});
                end
            end
            if (in_valid && in_ready) begin
                fr.push_back(in_dist);
                if (in_last || fr.size() == MC) begin
                    mi = 0;
                    for (int k = 1; k < fr.size(); k++)
                        if ($signed(fr[k]) < $signed(fr[mi])) mi = k;
                    e.d = fr[mi];
                    e.i = IW'(mi + 1);
                    e.c = IW'(fr.size());
                    e.o = !in_last;
                    expq.push_back(e);
                    fr.delete();
                end
            end
            prev_hold = out_valid && !out_ready;
            prev = {min_dist, min_idx, cand_cnt, ovf};
        end
    end

    task automatic beat(input logic [N-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_dist = d;
        in_last = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [N-1:0] d, input logic [IW-1:0] i,
                              input logic [IW-1:0] c, input logic o, input int hold);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, {min_dist, min_idx, cand_cnt, ovf}, {d, i, c, o});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_held"}, {out_valid, in_ready}, 2'b10);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_bubble"}, in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rnd();
        int r = $urandom_range(0, 9);
        return r == 0 ? 16'h8000 : r == 1 ? 16'h7fff : N'($urandom_range(0, 8)) - N'(4);
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {out_valid, in_ready, ovf, min_idx, cand_cnt, min_dist},
              {1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'd0});
        @(posedge clk);
        #1 rst = 1'b0;

        beat(16'd5, 0);
        beat(16'hfffd, 0);
        beat(16'd7, 0);
        beat(16'hfffd, 1);
        expect_res("ties", 16'hfffd, 3'd2, 3'd4, 1'b0, 0);

        beat(16'h8000, 1);
        expect_res("mostneg", 16'h8000, 3'd1, 3'd1, 1'b0, 2);

        beat(16'd9, 0);
        beat(16'd8, 0);
        beat(16'd7, 0);
        beat(16'd6, 0);
        expect_res("trunc", 16'd6, 3'd4, 3'd4, 1'b1, 0);
        beat(16'd1, 0);
        repeat (5) begin
            @(negedge clk);
            check("open", {out_valid, in_ready}, 2'b01);
        end
        @(posedge clk);
        #1;
        beat(16'd2, 1);
        expect_res("after_trunc", 16'd1, 3'd1, 3'd2, 1'b0, 0);

        beat(16'd3, 1);
        expect_res("stall", 16'd3, 3'd1, 3'd1, 1'b0, 5);

        beat(16'd10, 0);
        beat(16'd11, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid", {out_valid, in_ready, min_idx, cand_cnt}, {1'b0, 1'b1, 3'd0, 3'd0});
        @(posedge clk);
        #1;
        beat(16'd4, 0);
        beat(16'd3, 1);
        expect_res("post_rst", 16'd3, 3'd2, 3'd2, 1'b0, 0);

        beat(16'd1, 1);
        @(negedge clk);
        check("pre_rst_hold", out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_hold", {out_valid, in_ready, min_dist}, {1'b0, 1'b1, 16'd0});
        @(posedge clk);
        #1;

        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) begin
                        int g = $urandom_range(0, 2);
                        repeat (g) begin
                            @(posedge clk);
                            #1;
                        end
                        beat(rnd(), b == len - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("drain", expq.size() + fr.size(), 0);
        check("final_idle", {out_valid, in_ready}, 2'b01);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_argmin.md
STREAM_ARGMIN -- requirements
Module: stream_argmin

Interface
REQ-001 SHALL have parameter N, default 16, meaning distance word width in bits (two's complement).
REQ-002 SHALL have parameter Q, default 8, meaning fractional bits; compare-neutral, carried for the Q-format contract only.
REQ-003 SHALL have parameter MAX_CAND, default 16, meaning maximum candidates per frame (legal range 2..1024).
REQ-004 SHALL have derived localparam IDX_W = clog2(MAX_CAND+1), meaning index width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, meaning a candidate distance is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a candidate this cycle.
REQ-009 SHALL have port in_dist, input, N, meaning signed candidate distance.
REQ-010 SHALL have port in_last, input, 1, meaning the candidate is the final one of its frame.
REQ-011 SHALL have port out_valid, output, 1, meaning a frame result is held.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream consumes the result.
REQ-013 SHALL have port min_dist, output, N, meaning signed minimum of the frame.
REQ-014 SHALL have port min_idx, output, IDX_W, meaning 1-based position of the minimum (first candidate = 1; 0 never valid).
REQ-015 SHALL have port cand_cnt, output, IDX_W, meaning number of candidates in the frame.
REQ-016 SHALL have port ovf, output, 1, meaning the frame was truncated at MAX_CAND.

Function
REQ-017 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-018 Transfer SHALL occur on in_valid && in_ready; in_ready=1 in IDLE/ACC and 0 in HOLD.
REQ-019 IDLE plus a transfer SHALL load best=in_dist, best_idx=1, cnt=1, and go to ACC (or to HOLD if in_last).
REQ-020 ACC plus a transfer SHALL increment cnt and replace best/best_idx only if in_dist < best under signed compare (strict, so ties keep the lower index).
REQ-021 A transfer with in_last, or the one that makes cnt==MAX_CAND, SHALL complete the frame, go to HOLD, and register outputs the next cycle (latency 1 cycle from the last accepted beat to out_valid).
REQ-022 ovf SHALL be 1 only when the frame completes by reaching MAX_CAND without in_last on that beat; the following beats start a new frame.
REQ-023 In HOLD, out_valid=1; min_dist/min_idx/cand_cnt/ovf SHALL be stable until out_valid && out_ready.
REQ-024 HOLD with out_ready SHALL return to IDLE; no candidate is accepted in that same cycle (one bubble per frame).
REQ-025 The in_valid=0 cycles in ACC SHALL leave state unchanged; the frame has no timeout.
REQ-026 Outputs SHALL be registered; no combinational path from in_* to out_*.
REQ-027 The most-negative value SHALL compare correctly; no saturation or arithmetic on distances.

Reset
REQ-028 rst SHALL force IDLE, out_valid=0, min_dist=0, min_idx=0, cand_cnt=0, ovf=0, in_ready=1 on the next edge.
REQ-029 rst asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-030 rst SHALL override a simultaneous transfer or consume.

Structure
REQ-031 The shared package SHALL hold the FSM state enum and the clog2-based IDX_W helper.
REQ-032 The compare-and-select step SHALL be one sub-module, argmin_cell (N-bit signed a/b plus indices in; min value and index out, strict less-than).

Verification
REQ-033 Frame {5,-3,7,-3}, last on beat 4 -> one cycle later min_dist=-3, min_idx=2, cand_cnt=4, ovf=0.
REQ-034 Single-beat frame 0x8000 with last -> min_dist=0x8000, min_idx=1, cand_cnt=1.
REQ-035 MAX_CAND=4 with 6 beats {9,8,7,6,1,2} and no last -> first result min=6, idx=4, ovf=1; second frame {1,2} held open until its last beat, then min=1, idx=1, ovf=0.
REQ-036 out_ready low for 5 cycles in HOLD -> in_ready=0, outputs stable; consume, then the next frame starts after one bubble.
REQ-037 rst mid-frame after 2 beats -> no out_valid; the next frame {4,3} yields min=3, idx=2.
REQ-038 Random gaps in in_valid and random out_ready over 1000 frames -> results match a reference model with lowest-index tie-break.
